fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RISC-V pipeline: PC register, next-PC selection and IF/ID pipeline register. It consumes the stall/flush controls produced by the hazard detection unit (pc_write, if_id_write, flush_if_id) and the branch redirect from EX. It also keeps saturating stall and flush event counters for performance debug.

---
 rtl/fetch_stage.sv | 89 ++++++++
 tb/tb_fetch_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID pipeline register,
// and saturating stall/flush event counters for performance debug.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_write,
  input  logic             if_id_write,
  input  logic             flush_if_id,
  input  logic             pc_src,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      instr_in,
  output logic [31:0]      pc_out,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc_plus4,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  logic [31:0]      pc_p0;
  logic [31:0]      pc_plus4_p0;
  logic [31:0]      next_pc_p0;
  logic [31:0]      pc_p1;
  logic [31:0]      pc_plus4_p1;
  logic [31:0]      instr_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Stage p0: PC register and next-PC selection (redirect targets are word-aligned)
  assign pc_plus4_p0 = pc_p0 + 32'd4;
  assign next_pc_p0  = pc_src ? {branch_target[31:2], 2'b00} : pc_plus4_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p0 <= RESET_PC;
    end else if (pc_write) begin
      pc_p0 <= next_pc_p0;
    end
  end

  // Stage p1: IF/ID register; a flush wins over a held (stalled) register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p1       <= 32'd0;
      pc_plus4_p1 <= 32'd4;
      instr_p1    <= NOP_INSTR;
      vld_p1      <= 1'b0;
    end else if (flush_if_id) begin
      pc_p1       <= pc_p0;
      pc_plus4_p1 <= pc_plus4_p0;
      instr_p1    <= NOP_INSTR;
      vld_p1      <= 1'b0;
    end else if (if_id_write) begin
      pc_p1       <= pc_p0;
      pc_plus4_p1 <= pc_plus4_p0;
      instr_p1    <= instr_in;
      vld_p1      <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!if_id_write && !flush_if_id) stall_cnt <= sat_inc(stall_cnt);
      if (flush_if_id)                  flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign pc_out         = pc_p0;
  assign if_id_pc       = pc_p1;
  assign if_id_pc_plus4 = pc_plus4_p1;
  assign if_id_instr    = instr_p1;
  assign if_id_valid    = vld_p1;
  assign stall_count    = stall_cnt;
  assign flush_count    = flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: free run, stalls, redirect/flush, PC wrap,
// counter saturation and asynchronous reset mid-stall.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, pc_write, if_id_write, flush_if_id, pc_src;
  logic [31:0] branch_target, instr_in;
  logic [31:0] pc_out, if_id_pc, if_id_pc_plus4, if_id_instr;
  logic        if_id_valid;
  logic [15:0] stall_count, flush_count;

  logic        reset2;
  logic [31:0] instr2, pc2, if_id_pc2, if_id_pc_plus4_2, if_id_instr2;
  logic        if_id_valid2;
  logic [15:0] stall_count2, flush_count2;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign instr_in = 32'hA0 + pc_out;
  assign instr2   = 32'hA0 + pc2;

  fetch_stage dut (
    .clk(clk), .reset(reset), .pc_write(pc_write), .if_id_write(if_id_write),
    .flush_if_id(flush_if_id), .pc_src(pc_src), .branch_target(branch_target),
    .instr_in(instr_in), .pc_out(pc_out), .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .stall_count(stall_count), .flush_count(flush_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset2), .pc_write(1'b1), .if_id_write(1'b1),
    .flush_if_id(1'b0), .pc_src(1'b0), .branch_target(32'h0),
    .instr_in(instr2), .pc_out(pc2), .if_id_pc(if_id_pc2),
    .if_id_pc_plus4(if_id_pc_plus4_2), .if_id_instr(if_id_instr2),
    .if_id_valid(if_id_valid2), .stall_count(stall_count2), .flush_count(flush_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic vld);
    chk({tag, "_if_id_pc"}, if_id_pc, pc);
    chk({tag, "_if_id_pc_plus4"}, if_id_pc_plus4, pc + 32'd4);
    chk({tag, "_if_id_instr"}, if_id_instr, instr);
    chk({tag, "_if_id_valid"}, {31'd0, if_id_valid}, {31'd0, vld});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"}, pc_out, 32'h0);
    chk_ifid(tag, 32'h0, 32'h13, 1'b0);
    chk({tag, "_stall"}, {16'd0, stall_count}, 32'd0);
    chk({tag, "_flush"}, {16'd0, flush_count}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    pc_write = 1'b1; if_id_write = 1'b1; flush_if_id = 1'b0;
    pc_src = 1'b0; branch_target = 32'h0;
    repeat (2) step();
    chk_reset_state("rst");
    chk("wrap_rst_pc", pc2, 32'hFFFF_FFF8);
    reset = 1'b0; reset2 = 1'b0;

    // free run
    step();
    chk("run1_pc", pc_out, 32'h4);
    chk_ifid("run1", 32'h0, 32'hA0, 1'b1);
    chk("wrap1_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap1_if_id_pc", if_id_pc2, 32'hFFFF_FFF8);
    step();
    chk("run2_pc", pc_out, 32'h8);
    chk_ifid("run2", 32'h4, 32'hA4, 1'b1);
    chk("wrap2_pc", pc2, 32'h0);
    chk("wrap2_if_id_pc", if_id_pc2, 32'hFFFF_FFFC);
    chk("wrap2_if_id_pc_plus4", if_id_pc_plus4_2, 32'h0);
    chk("wrap2_instr", if_id_instr2, 32'h9C);

    // two-cycle load-use stall at pc 8
    pc_write = 1'b0; if_id_write = 1'b0;
    step();
    chk("stall1_pc", pc_out, 32'h8);
    chk_ifid("stall1", 32'h4, 32'hA4, 1'b1);
    chk("stall1_cnt", {16'd0, stall_count}, 32'd1);
    step();
    chk("stall2_pc", pc_out, 32'h8);
    chk_ifid("stall2", 32'h4, 32'hA4, 1'b1);
    chk("stall2_cnt", {16'd0, stall_count}, 32'd2);
    pc_write = 1'b1; if_id_write = 1'b1;
    step();
    chk("resume_pc", pc_out, 32'hC);
    chk_ifid("resume", 32'h8, 32'hA8, 1'b1);
    step();
    chk("run4_pc", pc_out, 32'h10);
    chk_ifid("run4", 32'hC, 32'hAC, 1'b1);

    // taken branch with flush; target low bits dropped
    pc_src = 1'b1; branch_target = 32'h0000_0103; flush_if_id = 1'b1;
    step();
    chk("br_pc", pc_out, 32'h100);
    chk_ifid("br", 32'h10, 32'h13, 1'b0);
    chk("br_flush_cnt", {16'd0, flush_count}, 32'd1);
    chk("br_stall_cnt", {16'd0, stall_count}, 32'd2);
    pc_src = 1'b0; flush_if_id = 1'b0;
    step();
    chk("tgt_pc", pc_out, 32'h104);
    chk_ifid("tgt", 32'h100, 32'h1A0, 1'b1);

    // flush overrides if_id_write=0; not counted as a stall
    pc_write = 1'b0; if_id_write = 1'b0; flush_if_id = 1'b1;
    step();
    chk("fls_pc", pc_out, 32'h104);
    chk_ifid("fls", 32'h104, 32'h13, 1'b0);
    chk("fls_stall_cnt", {16'd0, stall_count}, 32'd2);
    chk("fls_flush_cnt", {16'd0, flush_count}, 32'd2);
    pc_write = 1'b1; if_id_write = 1'b1; flush_if_id = 1'b0;
    step();
    chk("post_fls_pc", pc_out, 32'h108);
    chk_ifid("post_fls", 32'h104, 32'h1A4, 1'b1);

    // inconsistent: PC advances, IF/ID holds
    if_id_write = 1'b0;
    step();
    chk("inc_pc", pc_out, 32'h10C);
    chk_ifid("inc", 32'h104, 32'h1A4, 1'b1);
    chk("inc_stall_cnt", {16'd0, stall_count}, 32'd3);

    // long stall saturates the counter
    pc_write = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_stall_cnt", {16'd0, stall_count}, 32'h0000_FFFF);
    chk("sat_pc", pc_out, 32'h10C);
    chk("sat_flush_cnt", {16'd0, flush_count}, 32'd2);

    // asynchronous reset between edges, mid-stall
    #2 reset = 1'b1;
    #1;
    chk_reset_state("arst");
    step();
    reset = 1'b0;
    pc_write = 1'b1; if_id_write = 1'b1;
    step();
    chk("arst_run_pc", pc_out, 32'h4);
    chk_ifid("arst_run", 32'h0, 32'hA0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
